demux_1an_param: RTL and testbench
==================================

# demux_1an_param

Parametrised 1-to-N demultiplexer for the lane-splitting stage of the physical layer, running on the fast `clk_2f` domain. Successor to the fixed 8-bit 1-to-2 demux: width and output count are generic, each output channel has its own small FIFO with a valid/ready handshake, and input words are distributed round-robin. Back-pressure from any full channel stalls the input instead of dropping data.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits (≥1)
- `N_OUT`, 4, number of output channels (power of two, 2..16)
- `DEPTH`, 2, entries per output FIFO (power of two, 2..16)

Ports:
- `clk_2f`  in  1  single clock, all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `valid_in`  in  1  input word present
- `ready_in`  out  1  demux can accept the word this cycle
- `data_in`  in  WIDTH  input word
- `sel_in`  in  $clog2(N_OUT)  external channel select; exists only with `DEMUX_EXT_SEL_EN`
- `valid_out`  out  N_OUT  bit i: channel i FIFO non-empty
- `ready_out`  in  N_OUT  bit i: consumer pops channel i
- `data_out`  out  N_OUT*WIDTH  channel i head word at `[i*WIDTH +: WIDTH]`
- `sel_ptr`  out  $clog2(N_OUT)  current round-robin target channel

## Operation
- Accept condition: `valid_in && ready_in`. `ready_in` = 1 iff the target channel FIFO count < DEPTH. It is combinational from registered counts only, never from `ready_out`.
- Target channel: `sel_ptr` (round-robin mode), or `sel_in` (external mode).
- On accept: `data_in` is written to the target FIFO tail, and that channel's count increments.
- Round-robin mode: `sel_ptr` advances by 1 modulo N_OUT only on accept. Wrap from N_OUT-1 to 0. It holds while stalled or while `valid_in` = 0.
- Pop: when `valid_out[i] && ready_out[i]`, the head advances and the count decrements. `ready_out[i]` with `valid_out[i]` = 0 is ignored.
- Simultaneous push and pop on the same channel: the count is unchanged and both pointers advance. This is legal at any count, including count = DEPTH only if the push was accepted. Since `ready_in` uses the pre-pop count, no push occurs on a full channel.
- Channels are independent. A pop on channel j never affects the channel i count.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits.
- `data_out` for an empty channel holds the last-read storage value (don't-care). The bench must check data only when `valid_out` = 1.

## Timing
- Reset (asynchronous, any time, including mid-transfer):
  - all counts and pointers = 0
  - `sel_ptr` = 0
  - `valid_out` = 0
  - `ready_in` = 1
  - all FIFO contents discarded
  - storage is not reset; `data_out` is undefined until the first write
- Latency: a word accepted at edge k appears with `valid_out[i]` = 1 after edge k, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained when all consumers hold `ready_out` = 1.
- Stall: while the target channel is full, `ready_in` = 0 and the word must be held by the producer. A pop on that channel at edge k raises `ready_in` after edge k, so the stall costs 1 bubble.
- Deassertion of `reset` is synchronised by the integrator. Operation starts on the first edge after release.

## Configuration
- `DEMUX_EXT_SEL_EN` defined:
  - `sel_in` port present; the target channel is `sel_in`, sampled combinationally in the accept cycle
  - `sel_ptr` is tied to `sel_in`
  - out-of-range values cannot occur because N_OUT is a power of two
- Not defined:
  - no `sel_in` port
  - internal round-robin `sel_ptr` as described above

## Test plan
- Reset then stream: WIDTH=8, N_OUT=4, all `ready_out`=1, inputs 0x10,0x11,0x12,0x13,0x14 on consecutive cycles -> channels 0,1,2,3,0 receive them, each `valid_out` bit high 1 cycle later, `sel_ptr` = 1 at the end.
- Back-pressure: `ready_out`=0, DEPTH=2, 9 words offered continuously -> 8 accepted (2 per channel), `ready_in`=0 on the 9th with `sel_ptr`=0. Pulse `ready_out[0]` one cycle -> 0x?? head popped, 9th word accepted the next cycle.
- Simultaneous push/pop: channel 1 holding 1 word, push to channel 1 while popping it -> count stays 1, head becomes the new word, order preserved.
- Idle input: `valid_in`=0 for 5 cycles between words -> `sel_ptr` unchanged, no `valid_out` change.
- Reset mid-operation: assert `reset` asynchronously with channels half full -> `valid_out`=0 and `sel_ptr`=0 immediately, without waiting for a clock edge. The next word goes to channel 0.
- `DEMUX_EXT_SEL_EN`: `sel_in`=3,3,0 with 0xA0,0xA1,0xA2 -> channel 3 outputs 0xA0 then 0xA1 in order, channel 0 outputs 0xA2. With channel 3 full, `ready_in`=0 only while `sel_in`=3.

Source files
------------

// File: rtl/demux_1an_param.sv
// Parametrised 1-to-N demultiplexer with a per-channel FIFO and valid/ready handshakes.
// Optional build macro DEMUX_EXT_SEL_EN: the target channel comes from sel_in instead of the round-robin pointer.
module demux_1an_param #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk_2f,
    input  logic                       reset,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic [WIDTH-1:0]           data_in,
`ifdef DEMUX_EXT_SEL_EN
    input  logic [$clog2(N_OUT)-1:0]   sel_in,
`endif
    output logic [N_OUT-1:0]           valid_out,
    input  logic [N_OUT-1:0]           ready_out,
    output logic [N_OUT*WIDTH-1:0]     data_out,
    output logic [$clog2(N_OUT)-1:0]   sel_ptr
);

    localparam int SW = $clog2(N_OUT);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]    cnt_q    [N_OUT];
    logic [CW-1:0]    cnt_d    [N_OUT];
    logic [PW-1:0]    wr_ptr_q [N_OUT];
    logic [PW-1:0]    wr_ptr_d [N_OUT];
    logic [PW-1:0]    rd_ptr_q [N_OUT];
    logic [PW-1:0]    rd_ptr_d [N_OUT];
    logic [WIDTH-1:0] mem_q    [N_OUT][DEPTH];

    logic [SW-1:0]    target_s;
    logic             push_s;
    logic [N_OUT-1:0] push_ch_s;
    logic [N_OUT-1:0] pop_ch_s;

`ifdef DEMUX_EXT_SEL_EN
    assign target_s = sel_in;
    assign sel_ptr  = sel_in;
`else
    logic [SW-1:0] sel_ptr_q;
    logic [SW-1:0] sel_ptr_d;

    assign target_s = sel_ptr_q;
    assign sel_ptr  = sel_ptr_q;

    // Round-robin pointer moves only when a word is actually accepted.
    always_comb begin
        sel_ptr_d = sel_ptr_q;
        if (push_s) begin
            sel_ptr_d = sel_ptr_q + SW'(1);
        end else begin
            sel_ptr_d = sel_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            sel_ptr_q <= '0;
        end else begin
            sel_ptr_q <= sel_ptr_d;
        end
    end
`endif

    // Accept/pop decisions and next FIFO bookkeeping; ready_in looks only at pre-pop counts.
    always_comb begin
        ready_in  = (cnt_q[target_s] < CW'(DEPTH));
        push_s    = valid_in && ready_in;
        push_ch_s = '0;
        pop_ch_s  = '0;
        for (int i = 0; i < N_OUT; i++) begin
            push_ch_s[i] = push_s && (target_s == SW'(i));
            pop_ch_s[i]  = (cnt_q[i] != '0) && ready_out[i];
            cnt_d[i]     = cnt_q[i];
            wr_ptr_d[i]  = push_ch_s[i] ? (wr_ptr_q[i] + PW'(1)) : wr_ptr_q[i];
            rd_ptr_d[i]  = pop_ch_s[i]  ? (rd_ptr_q[i] + PW'(1)) : rd_ptr_q[i];
            case ({push_ch_s[i], pop_ch_s[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Output view of each channel: non-empty flag and head word.
    always_comb begin
        valid_out = '0;
        data_out  = '0;
        for (int i = 0; i < N_OUT; i++) begin
            valid_out[i]                = (cnt_q[i] != '0);
            data_out[i*WIDTH +: WIDTH]  = mem_q[i][rd_ptr_q[i]];
        end
    end

    // Counts and pointers; contents are discarded by clearing these.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i]    <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i]    <= cnt_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
        end
    end

    // FIFO storage, intentionally not reset.
    always_ff @(posedge clk_2f) begin
        for (int i = 0; i < N_OUT; i++) begin
            if (push_ch_s[i]) begin
                mem_q[i][wr_ptr_q[i]] <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_demux_1an_param.sv
// Directed bench for demux_1an_param with a per-channel scoreboard of expected words.
module tb_demux_1an_param;

    localparam int WIDTH = 8;
    localparam int N_OUT = 4;
    localparam int DEPTH = 2;

    logic                   clk_2f = 1'b0;
    logic                   reset;
    logic                   valid_in;
    logic                   ready_in;
    logic [WIDTH-1:0]       data_in;
`ifdef DEMUX_EXT_SEL_EN
    logic [1:0]             sel_in;
`endif
    logic [N_OUT-1:0]       valid_out;
    logic [N_OUT-1:0]       ready_out;
    logic [N_OUT*WIDTH-1:0] data_out;
    logic [1:0]             sel_ptr;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;
    logic [WIDTH-1:0] exp_q [N_OUT][$];

    demux_1an_param #(.WIDTH(WIDTH), .N_OUT(N_OUT), .DEPTH(DEPTH)) dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
`ifdef DEMUX_EXT_SEL_EN
        .sel_in    (sel_in),
`endif
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .sel_ptr   (sel_ptr)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int target();
`ifdef DEMUX_EXT_SEL_EN
        return int'(sel_in);
`else
        return m_ptr;
`endif
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N_OUT; i++) exp_q[i].delete();
        m_ptr = 0;
    endtask

    // One clock: check state against the model, retire pops, record a push, then advance.
    task automatic cycle(output bit acc);
        int t;
        bit rdy;
        logic [N_OUT-1:0] vexp;
        t   = target();
        rdy = (exp_q[t].size() < DEPTH);
        for (int i = 0; i < N_OUT; i++) vexp[i] = (exp_q[i].size() != 0);
        check("valid_out", 32'(valid_out), 32'(vexp));
        check("ready_in", 32'(ready_in), 32'(rdy));
        check("sel_ptr", 32'(sel_ptr), 32'(t));
        for (int i = 0; i < N_OUT; i++) begin
            if (vexp[i] && ready_out[i]) begin
                check($sformatf("data_out_ch%0d", i), 32'(data_out[i*WIDTH +: WIDTH]), 32'(exp_q[i][0]));
                void'(exp_q[i].pop_front());
            end
        end
        acc = valid_in && rdy;
        if (acc) begin
            exp_q[t].push_back(data_in);
            m_ptr = (m_ptr + 1) % N_OUT;
        end
        @(posedge clk_2f);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        bit acc;
        valid_in = 1'b1;
        data_in  = d;
        acc      = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) cycle(acc);
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        valid_in = 1'b0;
        for (int k = 0; k < n; k++) cycle(acc);
    endtask

    initial begin
        bit acc;
        reset     = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        ready_out = '0;
`ifdef DEMUX_EXT_SEL_EN
        sel_in    = 2'd0;
`endif
        #1;
        check("reset_valid_out", 32'(valid_out), 32'd0);
        check("reset_ready_in", 32'(ready_in), 32'd1);
        check("reset_sel_ptr", 32'(sel_ptr), 32'd0);
        @(posedge clk_2f);
        #1;
        reset = 1'b0;
        clear_model();

`ifdef DEMUX_EXT_SEL_EN
        sel_in = 2'd3;
        send(8'hA0);
        send(8'hA1);
        sel_in = 2'd0;
        send(8'hA2);
        valid_in = 1'b1;
        data_in  = 8'hA3;
        sel_in   = 2'd3;
        #1;
        check("ext_full_ready_in", 32'(ready_in), 32'd0);
        sel_in = 2'd1;
        #1;
        check("ext_other_ready_in", 32'(ready_in), 32'd1);
        check("ext_sel_ptr_tie", 32'(sel_ptr), 32'd1);
        valid_in  = 1'b0;
        ready_out = 4'hF;
        idle(3);
`else
        // Streaming, all consumers ready.
        ready_out = 4'hF;
        for (int w = 8'h10; w <= 8'h14; w++) send(WIDTH'(w));
        valid_in = 1'b0;
        check("stream_sel_ptr", 32'(sel_ptr), 32'd1);
        idle(3);

        // Idle input with one word parked in channel 1.
        ready_out = 4'h0;
        send(8'h15);
        idle(5);
        check("idle_sel_ptr", 32'(sel_ptr), 32'd2);
        check("idle_valid_out", 32'(valid_out), 32'h2);
        ready_out = 4'hF;
        idle(2);

        // Back-pressure after a reset pulse away from the clock edge.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        clear_model();
        ready_out = 4'h0;
        for (int w = 8'h20; w <= 8'h27; w++) send(WIDTH'(w));
        valid_in = 1'b1;
        data_in  = 8'h28;
        check("bp_stall_ready_in", 32'(ready_in), 32'd0);
        check("bp_stall_sel_ptr", 32'(sel_ptr), 32'd0);
        cycle(acc);
        check("bp_stall_acc", 32'(acc), 32'd0);
        ready_out = 4'b0001;
        cycle(acc);
        check("bp_pop_cycle_acc", 32'(acc), 32'd0);
        ready_out = 4'h0;
        cycle(acc);
        check("bp_ninth_acc", 32'(acc), 32'd1);
        ready_out = 4'hF;
        idle(4);

        // Simultaneous push and pop on channel 1.
        ready_out = 4'h0;
        send(8'h30);
        send(8'h31);
        send(8'h32);
        send(8'h33);
        ready_out = 4'b0010;
        send(8'h34);
        ready_out = 4'h0;
        valid_in  = 1'b0;
        check("pp_ch1_still_valid", 32'(valid_out[1]), 32'd1);
        idle(1);
        ready_out = 4'b0010;
        idle(1);
        ready_out = 4'hF;
        idle(2);

        // Asynchronous reset with words in flight.
        ready_out = 4'h0;
        send(8'h35);
        send(8'h36);
        send(8'h37);
        valid_in = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_valid_out", 32'(valid_out), 32'd0);
        check("async_rst_sel_ptr", 32'(sel_ptr), 32'd0);
        check("async_rst_ready_in", 32'(ready_in), 32'd1);
        clear_model();
        #1;
        reset = 1'b0;
        send(8'h40);
        valid_in = 1'b0;
        check("post_rst_ch0", 32'(valid_out), 32'h1);
        ready_out = 4'hF;
        idle(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
